logic_unit_pipe: RTL and testbench
==================================

// Module: logic_unit_pipe
// PURPOSE
//  Parametrised, registered bitwise logic unit: selects one of 8 gate functions on WIDTH-bit operands.
//  Adds valid/ready handshaking, a 1-cycle output register and a burst-accumulate (fold) mode.
//  Sits between an operand source and a result sink in datapath designs.
// PARAMETERS
//  WIDTH      8   operand/result width in bits (>=1)
//  MAX_BEATS  16  saturation value of the burst beat counter (>=1)
//  CNT_W      $clog2(MAX_BEATS+1)  width of out_count (derived; do not override)
// PORTS
//  clk        in   1        single clock, rising edge
//  rst_n      in   1        asynchronous, active-low reset
//  in_valid   in   1        operand beat valid
//  in_ready   out  1        unit can accept a beat
//  in_op      in   3        0 AND, 1 OR, 2 NOT(~a), 3 NAND, 4 NOR, 5 XOR, 6 XNOR, 7 PASS(a)
//  in_acc     in   1        1 = beat belongs to an accumulate burst
//  in_last    in   1        last beat of burst (ignored when in_acc=0)
//  in_a       in   WIDTH    operand A
//  in_b       in   WIDTH    operand B (ignored in accumulate mode)
//  out_valid  out  1        result valid
//  out_ready  in   1        sink accepts result
//  out_y      out  WIDTH    result
//  out_count  out  CNT_W    beats folded into out_y (1 in single mode)
// BEHAVIOUR
//  - Reset: out_valid=0, out_y=0, out_count=0, acc=0, beat counter=0, state=IDLE; async assert, sync-to-clk deassert handled upstream.
//  - in_ready = !out_valid || out_ready (combinational). Beat accepted when in_valid && in_ready.
//  - Output holds out_y/out_count stable while out_valid && !out_ready.
//  - Single mode (in_acc=0, state IDLE): out_y <= f(in_op,in_a,in_b), out_count <= 1, out_valid <= 1 next cycle. Latency 1.
//  - FSM states IDLE, ACCUM.
//    IDLE + accept + in_acc=1 + !in_last: acc <= in_a, op latched, cnt <= 1, go ACCUM.
//    IDLE + accept + in_acc=1 + in_last: out_y <= in_a, out_count <= 1, out_valid <= 1, stay IDLE.
//    ACCUM + accept: acc' = f(op_latched, acc, in_a); cnt saturates at MAX_BEATS.
//      !in_last: acc <= acc', no output. in_last: out_y <= acc', out_count <= cnt+1 (sat), out_valid <= 1, go IDLE.
//    In ACCUM, in_op and in_acc of later beats are ignored; burst ends only on in_last.
//    NOT and PASS in accumulate mode fold as PASS (acc <= in_a).
//  - out_valid clears when out_ready=1 and no new result is produced the same cycle; simultaneous
//    consume + new result keeps out_valid=1 with new data.
//  - Reset mid-burst: partial accumulation discarded, FSM returns to IDLE, no output emitted.
//  - All arithmetic is bitwise, WIDTH bits; no carries; counter never wraps.
// CONFIGURATION
//  LOGIC_UNIT_FLAGS_EN defined: adds ports out_zero (1, out_y==0) and out_parity (1, ^out_y),
//    registered alongside out_y, reset to 0, same valid/hold rules.
//  Undefined: those ports and registers do not exist; all other behaviour identical.
// STRUCTURE
//  Package logic_unit_pkg: op_e enum (8 codes above), state_e {IDLE, ACCUM}, OP_W=3.
//  Sub-module logic_op_core: purely combinational f(op, x, y) over WIDTH bits; instanced once,
//    operands muxed (a,b) in single mode vs (acc,a) in ACCUM.
//  Top: handshake, FSM, accumulator, counter, output register.
// TESTING (WIDTH=8, MAX_BEATS=16)
//  1. Single AND a=F0 b=3C, out_ready=1 -> out_y=30, out_count=1, out_valid 1 cycle after accept.
//  2. Single XNOR a=AA b=55 -> out_y=00; with FLAGS_EN out_zero=1, out_parity=0.
//  3. out_ready=0, two beats offered -> first result held stable, in_ready=0 until out_ready=1.
//  4. Acc XOR burst a=01,02,04, last on 3rd -> one result out_y=07, out_count=3, no earlier out_valid.
//  5. rst_n low after 2nd beat of OR burst -> out_valid=0, IDLE; then single OR 0F|F0 -> FF.
//  6. Acc OR burst of 20 beats -> out_count=16 (saturated), out_y = OR of all 20 a values.

Source files
------------

// File: rtl/logic_unit_pkg.sv
// Shared types for the logic unit: gate opcodes, burst FSM states and the fold-op mapping.
package logic_unit_pkg;

  localparam int OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    OP_AND  = 3'd0,
    OP_OR   = 3'd1,
    OP_NOT  = 3'd2,
    OP_NAND = 3'd3,
    OP_NOR  = 3'd4,
    OP_XOR  = 3'd5,
    OP_XNOR = 3'd6,
    OP_PASS = 3'd7
  } op_e;

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } state_e;

  // Unary ops have no meaningful fold; both collapse to taking the newest beat.
  function automatic op_e fold_op(input op_e op);
    return (op == OP_NOT || op == OP_PASS) ? OP_PASS : op;
  endfunction

endpackage

// File: rtl/logic_unit_if.sv
// Operand/result handshake bundle for logic_unit_pipe; flag outputs exist only with LOGIC_UNIT_FLAGS_EN.
interface logic_unit_if
  import logic_unit_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int MAX_BEATS = 16
);
  localparam int CNT_W = $clog2(MAX_BEATS + 1);

  logic             in_valid;
  logic             in_ready;
  logic [OP_W-1:0]  in_op;
  logic             in_acc;
  logic             in_last;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_y;
  logic [CNT_W-1:0] out_count;
`ifdef LOGIC_UNIT_FLAGS_EN
  logic             out_zero;
  logic             out_parity;
`endif

  modport master (
    output in_valid, in_op, in_acc, in_last, in_a, in_b, out_ready,
`ifdef LOGIC_UNIT_FLAGS_EN
    input  out_zero, out_parity,
`endif
    input  in_ready, out_valid, out_y, out_count
  );

  modport slave (
    input  in_valid, in_op, in_acc, in_last, in_a, in_b, out_ready,
`ifdef LOGIC_UNIT_FLAGS_EN
    output out_zero, out_parity,
`endif
    output in_ready, out_valid, out_y, out_count
  );

endinterface

// File: rtl/logic_op_core.sv
// Combinational gate function f(op, x, y) over WIDTH bits; PASS and NOT act on x only.
module logic_op_core
  import logic_unit_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  op_e              op,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] f
);

  always_comb begin
    f = x;
    case (op)
      OP_AND:  f = x & y;
      OP_OR:   f = x | y;
      OP_NOT:  f = ~x;
      OP_NAND: f = ~(x & y);
      OP_NOR:  f = ~(x | y);
      OP_XOR:  f = x ^ y;
      OP_XNOR: f = ~(x ^ y);
      OP_PASS: f = x;
      default: f = x;
    endcase
  end

endmodule

// File: rtl/logic_unit_pipe.sv
// Registered bitwise logic unit with valid/ready handshake and burst fold mode.
// Define LOGIC_UNIT_FLAGS_EN to add registered out_zero/out_parity flags.
module logic_unit_pipe
  import logic_unit_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int MAX_BEATS = 16
) (
  input logic         clk,
  input logic         rst_n,
  logic_unit_if.slave bus
);

  localparam int CNT_W = $clog2(MAX_BEATS + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BEATS);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c >= CNT_MAX) ? CNT_MAX : c + CNT_ONE;
  endfunction

  state_e           state;
  op_e              op_q;
  logic [WIDTH-1:0] acc;
  logic [CNT_W-1:0] cnt;

  logic             vld_p1;
  logic [WIDTH-1:0] y_p1;
  logic [CNT_W-1:0] count_p1;

  logic             in_ready;
  logic             accept;
  op_e              core_op;
  logic [WIDTH-1:0] core_y;
  logic [WIDTH-1:0] core_f;
  logic             produce;
  logic [WIDTH-1:0] y_nxt;
  logic [CNT_W-1:0] count_nxt;

  assign in_ready     = !vld_p1 || bus.out_ready;
  assign accept       = bus.in_valid && in_ready;
  assign bus.in_ready = in_ready;

  // All folded ops are commutative, so the accumulator rides on the y input
  // and in_a stays on x; PASS then naturally yields the newest beat.
  always_comb begin
    core_op = op_e'(bus.in_op);
    core_y  = bus.in_b;
    if (state == ACCUM) begin
      core_op = op_q;
      core_y  = acc;
    end
  end

  logic_op_core #(.WIDTH(WIDTH)) u_core (
    .op (core_op),
    .x  (bus.in_a),
    .y  (core_y),
    .f  (core_f)
  );

  always_comb begin
    produce   = 1'b0;
    y_nxt     = core_f;
    count_nxt = CNT_ONE;
    if (accept) begin
      if (state == ACCUM) begin
        produce   = bus.in_last;
        count_nxt = sat_inc(cnt);
      end else if (!bus.in_acc) begin
        produce = 1'b1;
      end else if (bus.in_last) begin
        produce = 1'b1;
        y_nxt   = bus.in_a;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      op_q  <= OP_PASS;
      acc   <= '0;
      cnt   <= '0;
    end else if (accept) begin
      case (state)
        IDLE: begin
          if (bus.in_acc && !bus.in_last) begin
            acc   <= bus.in_a;
            op_q  <= fold_op(op_e'(bus.in_op));
            cnt   <= CNT_ONE;
            state <= ACCUM;
          end
        end
        ACCUM: begin
          if (bus.in_last) begin
            cnt   <= '0;
            state <= IDLE;
          end else begin
            acc <= core_f;
            cnt <= sat_inc(cnt);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Output stage (p1): load on a new result, otherwise drop valid once consumed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1   <= 1'b0;
      y_p1     <= '0;
      count_p1 <= '0;
    end else if (produce) begin
      vld_p1   <= 1'b1;
      y_p1     <= y_nxt;
      count_p1 <= count_nxt;
    end else if (bus.out_ready) begin
      vld_p1   <= 1'b0;
    end
  end

  assign bus.out_valid = vld_p1;
  assign bus.out_y     = y_p1;
  assign bus.out_count = count_p1;

`ifdef LOGIC_UNIT_FLAGS_EN
  logic zero_p1;
  logic parity_p1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zero_p1   <= 1'b0;
      parity_p1 <= 1'b0;
    end else if (produce) begin
      zero_p1   <= (y_nxt == '0);
      parity_p1 <= ^y_nxt;
    end
  end

  assign bus.out_zero   = zero_p1;
  assign bus.out_parity = parity_p1;
`endif

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Directed self-checking bench for logic_unit_pipe (WIDTH=8, MAX_BEATS=16).
module tb_logic_unit_pipe;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  logic_unit_if #(.WIDTH(8), .MAX_BEATS(16)) bus ();

  logic_unit_pipe #(.WIDTH(8), .MAX_BEATS(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] op, input logic acc, input logic last,
                       input logic [7:0] a, input logic [7:0] b);
    bus.in_valid = 1'b1;
    bus.in_op    = op;
    bus.in_acc   = acc;
    bus.in_last  = last;
    bus.in_a     = a;
    bus.in_b     = b;
  endtask

  task automatic send(input logic [2:0] op, input logic acc, input logic last,
                      input logic [7:0] a, input logic [7:0] b);
    drive(op, acc, last, a, b);
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic chk_out(input string tag, input logic [7:0] y, input logic [4:0] c);
    chk({tag, "_valid"}, 32'(bus.out_valid), 32'h1);
    chk({tag, "_y"},     32'(bus.out_y),     32'(y));
    chk({tag, "_count"}, 32'(bus.out_count), 32'(c));
`ifdef LOGIC_UNIT_FLAGS_EN
    chk({tag, "_zero"},   32'(bus.out_zero),   32'(y == 8'h00));
    chk({tag, "_parity"}, 32'(bus.out_parity), 32'(^y));
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  logic [7:0] op_exp [8];
  logic [7:0] a6;
  logic [7:0] or6;

  initial begin
    n_checks      = 0;
    n_errors      = 0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_op     = 3'd0;
    bus.in_acc    = 1'b0;
    bus.in_last   = 1'b0;
    bus.in_a      = 8'h00;
    bus.in_b      = 8'h00;
    bus.out_ready = 1'b1;
    tick();
    tick();
    chk("rst_valid", 32'(bus.out_valid), 32'h0);
    chk("rst_y",     32'(bus.out_y),     32'h0);
    chk("rst_count", 32'(bus.out_count), 32'h0);
    chk("rst_ready", 32'(bus.in_ready),  32'h1);
    rst_n = 1'b1;
    tick();

    // 1: single AND, latency 1
    drive(3'd0, 1'b0, 1'b0, 8'hF0, 8'h3C);
    chk("t1_pre_valid", 32'(bus.out_valid), 32'h0);
    tick();
    bus.in_valid = 1'b0;
    chk_out("t1", 8'h30, 5'd1);
    tick();
    chk("t1_drain", 32'(bus.out_valid), 32'h0);

    // 2: single XNOR giving zero
    send(3'd6, 1'b0, 1'b0, 8'hAA, 8'h55);
    chk_out("t2", 8'h00, 5'd1);
    tick();

    // all eight ops back-to-back on CA/5C
    op_exp = '{8'h48, 8'hDE, 8'h35, 8'hB7, 8'h21, 8'h96, 8'h69, 8'hCA};
    for (int i = 0; i < 8; i++) begin
      send(3'(i), 1'b0, 1'b0, 8'hCA, 8'h5C);
      chk_out($sformatf("op%0d", i), op_exp[i], 5'd1);
    end
    tick();

    // 3: backpressure holds the first result
    bus.out_ready = 1'b0;
    send(3'd1, 1'b0, 1'b0, 8'h0F, 8'h30);
    drive(3'd0, 1'b0, 1'b0, 8'hFF, 8'h01);
    chk("t3_ready_lo", 32'(bus.in_ready), 32'h0);
    tick();
    tick();
    chk_out("t3_hold", 8'h3F, 5'd1);
    chk("t3_ready_lo2", 32'(bus.in_ready), 32'h0);
    bus.out_ready = 1'b1;
    #1;
    chk("t3_ready_hi", 32'(bus.in_ready), 32'h1);
    tick();
    bus.in_valid = 1'b0;
    chk_out("t3_second", 8'h01, 5'd1);
    tick();
    chk("t3_drain", 32'(bus.out_valid), 32'h0);

    // 4: XOR burst; later in_op/in_acc ignored
    send(3'd5, 1'b1, 1'b0, 8'h01, 8'hFF);
    chk("t4_b1_valid", 32'(bus.out_valid), 32'h0);
    send(3'd0, 1'b0, 1'b0, 8'h02, 8'hFF);
    chk("t4_b2_valid", 32'(bus.out_valid), 32'h0);
    send(3'd0, 1'b1, 1'b1, 8'h04, 8'hFF);
    chk_out("t4", 8'h07, 5'd3);
    tick();

    // single-beat burst passes in_a straight through
    send(3'd0, 1'b1, 1'b1, 8'h5A, 8'h00);
    chk_out("t4b", 8'h5A, 5'd1);
    tick();

    // NOT folds as PASS: last beat wins
    send(3'd2, 1'b1, 1'b0, 8'h0F, 8'h00);
    send(3'd2, 1'b1, 1'b1, 8'hF0, 8'h00);
    chk_out("t4c", 8'hF0, 5'd2);
    tick();

    // 5: reset mid OR burst
    send(3'd1, 1'b1, 1'b0, 8'h11, 8'h00);
    send(3'd1, 1'b1, 1'b0, 8'h22, 8'h00);
    chk("t5_pre_valid", 32'(bus.out_valid), 32'h0);
    rst_n = 1'b0;
    #2;
    chk("t5_rst_valid", 32'(bus.out_valid), 32'h0);
    chk("t5_rst_y",     32'(bus.out_y),     32'h0);
    tick();
    rst_n = 1'b1;
    tick();
    send(3'd1, 1'b0, 1'b0, 8'h0F, 8'hF0);
    chk_out("t5", 8'hFF, 5'd1);
    tick();

    // 6: 20-beat OR burst saturates the counter
    or6 = 8'h00;
    for (int i = 0; i < 20; i++) begin
      a6 = (i == 0) ? 8'h80 : (i == 19) ? 8'h10 : 8'h02;
      or6 = or6 | a6;
      send(3'd1, 1'b1, (i == 19), a6, 8'h00);
      if (i == 17) chk("t6_mid_valid", 32'(bus.out_valid), 32'h0);
    end
    chk_out("t6", 8'h92, 5'd16);
    chk("t6_model", 32'(or6), 32'h92);
    tick();
    chk("t6_drain", 32'(bus.out_valid), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
